// File: rtl/tpi_pkg.sv
// Shared types and constants for the TPI register-bus sequencer.
package tpi_pkg;

    localparam int CNT_W = 4;

    typedef logic [CNT_W-1:0] cnt_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_HOLD
    } tpi_state_e;

    localparam logic [2:0] RS_PRA  = 3'd0;
    localparam logic [2:0] RS_PRB  = 3'd1;
    localparam logic [2:0] RS_PRC  = 3'd2;
    localparam logic [2:0] RS_DDRA = 3'd3;
    localparam logic [2:0] RS_DDRB = 3'd4;
    localparam logic [2:0] RS_DDRC = 3'd5;

    // Counter reload value for a phase lasting n cycles.
    function automatic cnt_t cyc_load(input int unsigned n);
        return cnt_t'(n - 1);
    endfunction

endpackage

// File: rtl/tpi_rr_arbiter.sv
// Two-way round-robin arbiter; a tie goes to the requester not served last.
module tpi_rr_arbiter (
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic i_req0,
    input  logic i_req1,
    input  logic i_upd,
    input  logic i_upd_idx,
    output logic o_gnt_idx,
    output logic o_gnt_vld
);

    logic r_last;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_last <= 1'b1;
        end else if (i_upd) begin
            r_last <= i_upd_idx;
        end
    end

    always_comb begin
        o_gnt_vld = i_req0 | i_req1;
        o_gnt_idx = 1'b0;
        if (i_req0 && i_req1) begin
            o_gnt_idx = ~r_last;
        end else if (i_req1) begin
            o_gnt_idx = 1'b1;
        end
    end

endmodule

// File: rtl/tpi_bus_sequencer.sv
// Two-requester bus master running timed setup/strobe/hold TPI register accesses.
module tpi_bus_sequencer
    import tpi_pkg::*;
#(
    parameter int unsigned SETUP_CYC  = 2,
    parameter int unsigned STROBE_CYC = 4,
    parameter int unsigned HOLD_CYC   = 2
) (
    input  logic       clk,
    input  logic       _reset,
    input  logic       req0,
    input  logic       req1,
    input  logic       req0_we,
    input  logic       req1_we,
    input  logic [2:0] req0_rs,
    input  logic [2:0] req1_rs,
    input  logic [7:0] req0_wdata,
    input  logic [7:0] req1_wdata,
    output logic       ack0,
    output logic       ack1,
    output logic [7:0] rdata,
    output logic       busy,
    output logic [2:0] rs,
    output logic       _write,
    output logic       _cs,
    output logic [7:0] data_o,
    output logic       data_oe,
    input  logic [7:0] data_i
);

    localparam cnt_t LD_SETUP  = cyc_load(SETUP_CYC);
    localparam cnt_t LD_STROBE = cyc_load(STROBE_CYC);
    localparam cnt_t LD_HOLD   = cyc_load(HOLD_CYC);

    tpi_state_e r_state;
    tpi_state_e w_state_nxt;
    cnt_t       r_cnt;
    cnt_t       w_cnt_nxt;

    logic       r_gnt;
    logic       r_we;
    logic [2:0] r_rs;
    logic [7:0] r_wdata;

    logic       w_gnt_nxt;
    logic       w_we_nxt;
    logic [2:0] w_rs_nxt;
    logic [7:0] w_wd_nxt;

    logic       r_cs;
    logic       r_write;
    logic [2:0] r_rs_o;
    logic [7:0] r_data_o;
    logic       r_data_oe;
    logic       r_ack0;
    logic       r_ack1;
    logic [7:0] r_rdata;

    logic w_gnt_idx;
    logic w_gnt_vld;
    logic w_done;
    logic w_take;
    logic w_upd;

    assign w_done = (r_cnt == '0);
    assign w_take = (r_state == ST_IDLE) && w_gnt_vld;
    assign w_upd  = (r_state == ST_HOLD) && w_done;

    tpi_rr_arbiter u_arb (
        .i_clk     (clk),
        .i_reset_n (_reset),
        .i_req0    (req0),
        .i_req1    (req1),
        .i_upd     (w_upd),
        .i_upd_idx (r_gnt),
        .o_gnt_idx (w_gnt_idx),
        .o_gnt_vld (w_gnt_vld)
    );

    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt - cnt_t'(1);
        unique case (r_state)
            ST_IDLE: begin
                w_cnt_nxt = r_cnt;
                if (w_gnt_vld) begin
                    w_state_nxt = ST_SETUP;
                    w_cnt_nxt   = LD_SETUP;
                end
            end
            ST_SETUP: begin
                if (w_done) begin
                    w_state_nxt = ST_STROBE;
                    w_cnt_nxt   = LD_STROBE;
                end
            end
            ST_STROBE: begin
                if (w_done) begin
                    w_state_nxt = ST_HOLD;
                    w_cnt_nxt   = LD_HOLD;
                end
            end
            ST_HOLD: begin
                if (w_done) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Fields of the access being set up next cycle; taken straight from
    // the winning requester on grant so the pins change with SETUP entry.
    always_comb begin
        w_gnt_nxt = r_gnt;
        w_we_nxt  = r_we;
        w_rs_nxt  = r_rs;
        w_wd_nxt  = r_wdata;
        if (w_take) begin
            w_gnt_nxt = w_gnt_idx;
            w_we_nxt  = w_gnt_idx ? req1_we    : req0_we;
            w_rs_nxt  = w_gnt_idx ? req1_rs    : req0_rs;
            w_wd_nxt  = w_gnt_idx ? req1_wdata : req0_wdata;
        end
    end

    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            r_gnt   <= 1'b0;
            r_we    <= 1'b0;
            r_rs    <= '0;
            r_wdata <= '0;
        end else if (w_take) begin
            r_gnt   <= w_gnt_nxt;
            r_we    <= w_we_nxt;
            r_rs    <= w_rs_nxt;
            r_wdata <= w_wd_nxt;
        end
    end

    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            r_cs      <= 1'b1;
            r_write   <= 1'b1;
            r_rs_o    <= '0;
            r_data_o  <= '0;
            r_data_oe <= 1'b0;
            r_ack0    <= 1'b0;
            r_ack1    <= 1'b0;
            r_rdata   <= '0;
        end else begin
            r_ack0 <= 1'b0;
            r_ack1 <= 1'b0;
            if (w_state_nxt == ST_IDLE) begin
                r_cs      <= 1'b1;
                r_write   <= 1'b1;
                r_data_oe <= 1'b0;
            end else begin
                r_cs      <= (w_state_nxt != ST_STROBE);
                r_write   <= ~w_we_nxt;
                r_rs_o    <= w_rs_nxt;
                r_data_oe <= w_we_nxt;
                if (w_we_nxt) begin
                    r_data_o <= w_wd_nxt;
                end
            end
            // Pulse lands on the final HOLD cycle.
            if (w_state_nxt == ST_HOLD && w_cnt_nxt == '0) begin
                r_ack0 <= ~w_gnt_nxt;
                r_ack1 <= w_gnt_nxt;
            end
            if (r_state == ST_STROBE && w_done && !r_we) begin
                r_rdata <= data_i;
            end
        end
    end

    assign _cs     = r_cs;
    assign _write  = r_write;
    assign rs      = r_rs_o;
    assign data_o  = r_data_o;
    assign data_oe = r_data_oe;
    assign ack0    = r_ack0;
    assign ack1    = r_ack1;
    assign rdata   = r_rdata;
    assign busy    = (r_state != ST_IDLE);

endmodule

// File: tb/tb_tpi_bus_sequencer.sv
// Directed bench for tpi_bus_sequencer: default timing instance plus a 1/1/1 corner instance.
module tb_tpi_bus_sequencer;
    import tpi_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       req0, req1, req0_we, req1_we;
    logic [2:0] req0_rs, req1_rs;
    logic [7:0] req0_wd, req1_wd, data_i;
    logic       ack0, ack1, busy, wr_n, cs_n, data_oe;
    logic [7:0] rdata, data_o;
    logic [2:0] rs;

    logic       c_req0, c_req0_we;
    logic [2:0] c_req0_rs;
    logic [7:0] c_req0_wd;
    logic       c_ack0, c_ack1, c_busy, c_wr_n, c_cs_n, c_data_oe;
    logic [7:0] c_rdata, c_data_o;
    logic [2:0] c_rs;

    tpi_bus_sequencer u_dut (
        .clk(clk), ._reset(rst_n),
        .req0(req0), .req1(req1),
        .req0_we(req0_we), .req1_we(req1_we),
        .req0_rs(req0_rs), .req1_rs(req1_rs),
        .req0_wdata(req0_wd), .req1_wdata(req1_wd),
        .ack0(ack0), .ack1(ack1), .rdata(rdata), .busy(busy),
        .rs(rs), ._write(wr_n), ._cs(cs_n),
        .data_o(data_o), .data_oe(data_oe), .data_i(data_i)
    );

    tpi_bus_sequencer #(
        .SETUP_CYC(1), .STROBE_CYC(1), .HOLD_CYC(1)
    ) u_dut1 (
        .clk(clk), ._reset(rst_n),
        .req0(c_req0), .req1(1'b0),
        .req0_we(c_req0_we), .req1_we(1'b0),
        .req0_rs(c_req0_rs), .req1_rs(3'd0),
        .req0_wdata(c_req0_wd), .req1_wdata(8'h00),
        .ack0(c_ack0), .ack1(c_ack1), .rdata(c_rdata), .busy(c_busy),
        .rs(c_rs), ._write(c_wr_n), ._cs(c_cs_n),
        .data_o(c_data_o), .data_oe(c_data_oe), .data_i(8'h00)
    );

    logic [7:0] tpi_reg [8];
    always @(posedge cs_n) begin
        if (wr_n == 1'b0) tpi_reg[rs] = data_o;
    end

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        else
            n_pass++;
    endtask

    logic [63:0] m_cs, m_wr, m_oe, m_ack0, m_ack1, m_busy;
    logic [2:0]  h_rs [64];
    logic [7:0]  h_do [64];
    logic [7:0]  ack_rdata;
    int          gnt_q [$];
    int          n_ack;

    task automatic capture(input bit which, input int ncyc,
                           input int drop_at, input logic [2:0] rs_after);
        logic a;
        m_cs = '0; m_wr = '0; m_oe = '0;
        m_ack0 = '0; m_ack1 = '0; m_busy = '0;
        gnt_q.delete();
        n_ack = 0;
        for (int n = 0; n < ncyc; n++) begin
            @(negedge clk);
            if (!which) begin
                m_cs[n] = ~cs_n;   m_wr[n] = ~wr_n;  m_oe[n] = data_oe;
                m_ack0[n] = ack0;  m_ack1[n] = ack1; m_busy[n] = busy;
                h_rs[n] = rs;      h_do[n] = data_o;
                a = ack0 | ack1;
                if (a) begin
                    ack_rdata = rdata;
                    gnt_q.push_back(ack1 ? 1 : 0);
                    req0_rs = rs_after;
                end
            end else begin
                m_cs[n] = ~c_cs_n;  m_wr[n] = ~c_wr_n;  m_oe[n] = c_data_oe;
                m_ack0[n] = c_ack0; m_ack1[n] = c_ack1; m_busy[n] = c_busy;
                h_rs[n] = c_rs;     h_do[n] = c_data_o;
                a = c_ack0 | c_ack1;
            end
            if (a) n_ack++;
            if (a && n_ack >= drop_at) begin
                req0 = 1'b0; req1 = 1'b0; c_req0 = 1'b0;
            end
        end
    endtask

    logic [63:0] exp_busy;
    logic [3:0]  gv;
    int          seen;

    initial begin
        for (int i = 0; i < 8; i++) tpi_reg[i] = 8'h00;
        rst_n = 1'b0;
        req0 = 0; req1 = 0; req0_we = 0; req1_we = 0;
        req0_rs = 0; req1_rs = 0; req0_wd = 0; req1_wd = 0;
        data_i = 8'h00;
        c_req0 = 0; c_req0_we = 0; c_req0_rs = 0; c_req0_wd = 0;

        repeat (3) @(negedge clk);
        chk("rst_cs", cs_n, 1);
        chk("rst_write", wr_n, 1);
        chk("rst_rs_do", {rs, data_o}, 0);
        chk("rst_oe_busy", {data_oe, busy}, 0);
        chk("rst_acks", {ack0, ack1}, 0);
        chk("rst_rdata", rdata, 0);
        #2 rst_n = 1'b1;

        // single write, DDRA = 0xFF
        @(posedge clk); #1;
        req0 = 1; req0_we = 1; req0_rs = RS_DDRA; req0_wd = 8'hFF;
        capture(0, 10, 1, RS_DDRA);
        chk("wr_cs_low", m_cs, 64'h78);
        chk("wr_write_low", m_wr, 64'h1FE);
        chk("wr_oe", m_oe, 64'h1FE);
        chk("wr_ack0", m_ack0, 64'h100);
        chk("wr_ack1", m_ack1, 0);
        chk("wr_busy", m_busy, 64'h1FE);
        chk("wr_rs", h_rs[1], RS_DDRA);
        chk("wr_data", h_do[5], 8'hFF);
        chk("wr_ddra", tpi_reg[RS_DDRA], 8'hFF);

        // single read of port A pins
        @(posedge clk); #1;
        data_i = 8'hA5;
        req1 = 1; req1_we = 0; req1_rs = RS_PRA;
        capture(0, 10, 1, req0_rs);
        chk("rd_cs_low", m_cs, 64'h78);
        chk("rd_write", m_wr, 0);
        chk("rd_oe", m_oe, 0);
        chk("rd_ack1", m_ack1, 64'h100);
        chk("rd_ack0", m_ack0, 0);
        chk("rd_rdata", ack_rdata, 8'hA5);
        chk("rd_rs", h_rs[2], RS_PRA);
        data_i = 8'h00;
        repeat (3) @(negedge clk);
        chk("rd_rdata_held", rdata, 8'hA5);

        // contention: four accesses alternating 0,1,0,1
        @(posedge clk); #1;
        req0 = 1; req0_we = 1; req0_rs = RS_PRB; req0_wd = 8'h11;
        req1 = 1; req1_we = 1; req1_rs = RS_PRC; req1_wd = 8'h22;
        capture(0, 37, 4, RS_PRB);
        chk("ct_nack", n_ack, 4);
        gv = '0;
        foreach (gnt_q[i]) gv = {gv[2:0], gnt_q[i][0]};
        chk("ct_order", gv, 4'b0101);
        exp_busy = '0;
        for (int n = 0; n < 37; n++) if (n % 9 != 0) exp_busy[n] = 1'b1;
        chk("ct_busy", m_busy, exp_busy);
        chk("ct_ack0", m_ack0, (64'h1 << 8) | (64'h1 << 26));
        chk("ct_ack1", m_ack1, (64'h1 << 17) | (64'h1 << 35));
        chk("ct_rs", {h_rs[1], h_rs[10]}, {RS_PRB, RS_PRC});
        chk("ct_data", h_do[10], 8'h22);

        // back-to-back on req0 with rs re-latched
        @(posedge clk); #1;
        req0 = 1; req0_we = 1; req0_rs = RS_DDRB; req0_wd = 8'h44;
        capture(0, 19, 2, RS_DDRC);
        chk("bb_ack0", m_ack0, (64'h1 << 8) | (64'h1 << 17));
        chk("bb_busy", m_busy, 64'h1FE | (64'h1FE << 9));
        chk("bb_rs_first", h_rs[1], RS_DDRB);
        chk("bb_rs_idle", h_rs[9], RS_DDRB);
        chk("bb_rs_second", h_rs[10], RS_DDRC);

        // reset in the middle of a write strobe
        @(posedge clk); #1;
        req0 = 1; req0_we = 1; req0_rs = RS_DDRB; req0_wd = 8'h3C;
        repeat (5) @(negedge clk);
        chk("ab_pre_cs", cs_n, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("ab_cs_async", cs_n, 1);
        chk("ab_write_async", wr_n, 1);
        req0 = 0;
        seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (ack0 | ack1) seen++;
        end
        #2 rst_n = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (ack0 | ack1) seen++;
        end
        chk("ab_no_ack", seen, 0);
        chk("ab_idle", busy, 0);

        // pointer back at reset value: req0 wins the tie
        @(posedge clk); #1;
        req0 = 1; req0_we = 0; req0_rs = RS_PRB;
        req1 = 1; req1_we = 0; req1_rs = RS_PRC;
        capture(0, 10, 1, RS_PRB);
        chk("ab_tie_gnt", (gnt_q.size() > 0) ? gnt_q[0] : 99, 0);
        chk("ab_tie_ack0", m_ack0, 64'h100);

        // 1/1/1 timing corner
        @(posedge clk); #1;
        c_req0 = 1; c_req0_we = 1; c_req0_rs = RS_PRC; c_req0_wd = 8'h5A;
        capture(1, 6, 1, RS_PRA);
        chk("cn_cs_low", m_cs, 64'h4);
        chk("cn_ack0", m_ack0, 64'h8);
        chk("cn_write", m_wr, 64'hE);
        chk("cn_busy", m_busy, 64'hE);
        chk("cn_data", h_do[2], 8'h5A);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
